muldiv_ctrl: RTL and testbench



---
 rtl/muldiv_ctrl.sv | 211 +++++++++++++++++++++
 tb/tb_muldiv_ctrl.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/muldiv_ctrl.sv
// Purpose: signed 32x32 multiply / divide sequencer producing HI/LO, one step per cycle.
// Latency: 35 cycles from the start edge to the done cycle (optional divide-by-zero trap: 2 cycles).
// Backpressure: busy is held high from PREP through DONE; start is ignored while busy, with no queuing.
// Optional feature: define MULDIV_DIV0_TRAP_EN to trap DIV by zero in PREP (done+div0, HI/LO untouched).
module muldiv_ctrl (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        op,
   input  logic [31:0] a_in,
   input  logic [31:0] b_in,
   output logic        busy,
   output logic        done,
   output logic        hilo_w,
   output logic [31:0] hi_out,
   output logic [31:0] lo_out,
   output logic        div0
);

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      PREP = 3'd1,
      RUN  = 3'd2,
      FIX  = 3'd3,
      DONE = 3'd4
   } state_t;

   state_t      state_q, state_d;
   logic        op_q, op_d;
   logic [31:0] a_q, a_d;
   logic [31:0] b_q, b_d;
   logic [31:0] m_q, m_d;     // multiplicand or divisor magnitude
   logic [31:0] wh_q, wh_d;   // partial product high half / partial remainder
   logic [31:0] wl_q, wl_d;   // multiplier shifting out / quotient shifting in
   logic [31:0] hi_q, hi_d;
   logic [31:0] lo_q, lo_d;
   logic [5:0]  cnt_q, cnt_d;
   logic        qneg_q, qneg_d; // negate product or quotient in FIX
   logic        rneg_q, rneg_d; // negate remainder in FIX
`ifdef MULDIV_DIV0_TRAP_EN
   logic        dz_q, dz_d;
   logic        dz_hit;
`endif

   logic [31:0] a_mag;
   logic [31:0] b_mag;
   logic [32:0] mul_sum;
   logic [32:0] div_sh;
   logic [32:0] div_diff;
   logic [63:0] prod_neg;

   // Datapath helpers: operand magnitudes, add/subtract step, 64-bit negation.
   always_comb begin
      a_mag    = a_q[31] ? (32'd0 - a_q) : a_q;
      b_mag    = b_q[31] ? (32'd0 - b_q) : b_q;
      mul_sum  = {1'b0, wh_q} + {1'b0, m_q};
      div_sh   = {wh_q, wl_q[31]};
      div_diff = div_sh - {1'b0, m_q};
      prod_neg = 64'd0 - {wh_q, wl_q};
   end

`ifdef MULDIV_DIV0_TRAP_EN
   // Divide-by-zero detection on the captured divisor.
   always_comb begin
      dz_hit = op_q & (b_q == 32'd0);
   end
`endif

   // Next-state and datapath update for the sequencer.
   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      a_d     = a_q;
      b_d     = b_q;
      m_d     = m_q;
      wh_d    = wh_q;
      wl_d    = wl_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      cnt_d   = cnt_q;
      qneg_d  = qneg_q;
      rneg_d  = rneg_q;
`ifdef MULDIV_DIV0_TRAP_EN
      dz_d    = dz_q;
`endif
      case (state_q)
         IDLE: begin
            if (start) begin
               a_d     = a_in;
               b_d     = b_in;
               op_d    = op;
               state_d = PREP;
            end
         end
         PREP: begin
            cnt_d   = 6'd0;
            wh_d    = 32'd0;
            state_d = RUN;
            if (!op_q) begin
               m_d    = a_mag;
               wl_d   = b_mag;
               qneg_d = a_q[31] ^ b_q[31];
               rneg_d = 1'b0;
            end else begin
               m_d    = b_mag;
               wl_d   = a_mag;
               // A zero divisor yields an all-ones quotient; keep it unsigned-looking
               // so the result is 0xFFFFFFFF regardless of the dividend sign.
               qneg_d = (a_q[31] ^ b_q[31]) & (b_q != 32'd0);
               rneg_d = a_q[31];
            end
`ifdef MULDIV_DIV0_TRAP_EN
            dz_d = dz_hit;
            if (dz_hit) begin
               state_d = DONE;
            end
`endif
         end
         RUN: begin
            if (!op_q) begin
               if (wl_q[0]) begin
                  {wh_d, wl_d} = {mul_sum, wl_q[31:1]};
               end else begin
                  {wh_d, wl_d} = {1'b0, wh_q, wl_q[31:1]};
               end
            end else begin
               if (!div_diff[32]) begin
                  wh_d = div_diff[31:0];
                  wl_d = {wl_q[30:0], 1'b1};
               end else begin
                  wh_d = div_sh[31:0];
                  wl_d = {wl_q[30:0], 1'b0};
               end
            end
            cnt_d = cnt_q + 6'd1;
            if (cnt_q == 6'd31) begin
               state_d = FIX;
            end
         end
         FIX: begin
            // HI/LO load on the edge into DONE so they are visible alongside hilo_w.
            if (!op_q) begin
               {hi_d, lo_d} = qneg_q ? prod_neg : {wh_q, wl_q};
            end else begin
               lo_d = qneg_q ? (32'd0 - wl_q) : wl_q;
               hi_d = rneg_q ? (32'd0 - wh_q) : wh_q;
            end
            state_d = DONE;
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath registers; reset aborts any operation in flight.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         op_q    <= 1'b0;
         a_q     <= 32'd0;
         b_q     <= 32'd0;
         m_q     <= 32'd0;
         wh_q    <= 32'd0;
         wl_q    <= 32'd0;
         hi_q    <= 32'd0;
         lo_q    <= 32'd0;
         cnt_q   <= 6'd0;
         qneg_q  <= 1'b0;
         rneg_q  <= 1'b0;
`ifdef MULDIV_DIV0_TRAP_EN
         dz_q    <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         a_q     <= a_d;
         b_q     <= b_d;
         m_q     <= m_d;
         wh_q    <= wh_d;
         wl_q    <= wl_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         cnt_q   <= cnt_d;
         qneg_q  <= qneg_d;
         rneg_q  <= rneg_d;
`ifdef MULDIV_DIV0_TRAP_EN
         dz_q    <= dz_d;
`endif
      end
   end

   // Status outputs decode directly from the state register.
   always_comb begin
      busy   = (state_q != IDLE);
      done   = (state_q == DONE);
      hi_out = hi_q;
      lo_out = lo_q;
`ifdef MULDIV_DIV0_TRAP_EN
      hilo_w = (state_q == DONE) & ~dz_q;
      div0   = (state_q == DONE) & dz_q;
`else
      hilo_w = (state_q == DONE);
      div0   = 1'b0;
`endif
   end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed bench for muldiv_ctrl: multiply/divide results, cycle timing, busy/done strobes,
// ignored restart while busy, mid-operation reset abort and the divide-by-zero behaviour
// for whichever MULDIV_DIV0_TRAP_EN build is compiled.
module tb_muldiv_ctrl;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic        op = 1'b0;
   logic [31:0] a_in = 32'd0;
   logic [31:0] b_in = 32'd0;
   logic        busy, done, hilo_w, div0;
   logic [31:0] hi_out, lo_out;

   int checks = 0;
   int errors = 0;

   muldiv_ctrl dut (
      .clk    (clk),
      .reset  (reset),
      .start  (start),
      .op     (op),
      .a_in   (a_in),
      .b_in   (b_in),
      .busy   (busy),
      .done   (done),
      .hilo_w (hilo_w),
      .hi_out (hi_out),
      .lo_out (lo_out),
      .div0   (div0)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Drive start for edge C, then scramble the inputs to prove they were captured.
   task automatic launch(input string tag, input logic o, input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      op = o; a_in = a; b_in = b; start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0; op = ~o; a_in = ~a; b_in = ~b;
      chk({tag, "_prep_flags"}, {60'd0, busy, done, hilo_w, div0}, 64'h8);
   endtask

   // From cycle C+1, advance to cycle C+last; busy-only flags before, fl at the last cycle.
   task automatic run_to(input string tag, input int last, input logic [3:0] fl);
      for (int k = 2; k <= last; k++) begin
         @(posedge clk);
         #1;
         if (k < last) chk({tag, "_run_flags"}, {60'd0, busy, done, hilo_w, div0}, 64'h8);
      end
      chk({tag, "_done_flags"}, {60'd0, busy, done, hilo_w, div0}, {60'd0, fl});
   endtask

   task automatic chk_result(input string tag, input logic [31:0] hi, input logic [31:0] lo);
      chk({tag, "_hi"}, {32'd0, hi_out}, {32'd0, hi});
      chk({tag, "_lo"}, {32'd0, lo_out}, {32'd0, lo});
   endtask

   // One cycle after DONE: back in IDLE with HI/LO held.
   task automatic chk_idle(input string tag, input logic [31:0] hi, input logic [31:0] lo);
      @(posedge clk);
      #1;
      chk({tag, "_idle_flags"}, {60'd0, busy, done, hilo_w, div0}, 64'h0);
      chk_result({tag, "_hold"}, hi, lo);
   endtask

   initial begin
      logic seen_done;

      // Reset state
      #2 reset = 1'b0;
      #1;
      chk("rst_flags", {60'd0, busy, done, hilo_w, div0}, 64'h0);
      chk_result("rst", 32'h0, 32'h0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      chk("post_rst_idle", {60'd0, busy, done, hilo_w, div0}, 64'h0);

      // MULT 7 * -3 = -21
      launch("mul_7_m3", 1'b0, 32'd7, 32'hFFFF_FFFD);
      run_to("mul_7_m3", 35, 4'b1110);
      chk_result("mul_7_m3", 32'hFFFF_FFFF, 32'hFFFF_FFEB);
      chk_idle("mul_7_m3", 32'hFFFF_FFFF, 32'hFFFF_FFEB);

      // MULT min * min = 2^62
      launch("mul_min", 1'b0, 32'h8000_0000, 32'h8000_0000);
      run_to("mul_min", 35, 4'b1110);
      chk_result("mul_min", 32'h4000_0000, 32'h0000_0000);
      chk_idle("mul_min", 32'h4000_0000, 32'h0000_0000);

      // DIV -7 / 2 = -3 rem -1
      launch("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2);
      run_to("div_m7_2", 35, 4'b1110);
      chk_result("div_m7_2", 32'hFFFF_FFFF, 32'hFFFF_FFFD);
      chk_idle("div_m7_2", 32'hFFFF_FFFF, 32'hFFFF_FFFD);

      // DIV min / -1 wraps to min, remainder 0, no flag
      launch("div_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
      run_to("div_ovf", 35, 4'b1110);
      chk_result("div_ovf", 32'h0000_0000, 32'h8000_0000);
      chk_idle("div_ovf", 32'h0000_0000, 32'h8000_0000);

      // DIV 5 / 0
`ifdef MULDIV_DIV0_TRAP_EN
      launch("div0", 1'b1, 32'd5, 32'd0);
      run_to("div0", 2, 4'b1101);
      chk_result("div0_kept", 32'h0000_0000, 32'h8000_0000);
      chk_idle("div0", 32'h0000_0000, 32'h8000_0000);
`else
      launch("div0", 1'b1, 32'd5, 32'd0);
      run_to("div0", 35, 4'b1110);
      chk_result("div0", 32'd5, 32'hFFFF_FFFF);
      chk_idle("div0", 32'd5, 32'hFFFF_FFFF);
`endif

      // MULT -2 * -3 with a second start pulsed at C+10: ignored, single done at C+35
      launch("mul_restart", 1'b0, 32'hFFFF_FFFE, 32'hFFFF_FFFD);
      run_to("mul_restart_pre", 10, 4'b1000);
      op = 1'b1; a_in = 32'd100; b_in = 32'd7; start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      chk("mul_restart_c11_flags", {60'd0, busy, done, hilo_w, div0}, 64'h8);
      for (int k = 12; k <= 35; k++) begin
         @(posedge clk);
         #1;
         if (k < 35) chk("mul_restart_run_flags", {60'd0, busy, done, hilo_w, div0}, 64'h8);
      end
      chk("mul_restart_done_flags", {60'd0, busy, done, hilo_w, div0}, 64'hE);
      chk_result("mul_restart", 32'd0, 32'd6);
      seen_done = 1'b0;
      for (int k = 0; k < 40; k++) begin
         @(posedge clk);
         #1;
         if (done || busy) seen_done = 1'b1;
      end
      chk("mul_restart_no_queue", {63'd0, seen_done}, 64'd0);

      // MULT 16 * 16 aborted by reset at C+12
      launch("mul_abort", 1'b0, 32'd16, 32'd16);
      run_to("mul_abort_pre", 12, 4'b1000);
      reset = 1'b0;
      #1;
      chk("abort_flags", {60'd0, busy, done, hilo_w, div0}, 64'h0);
      chk_result("abort", 32'h0, 32'h0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      seen_done = 1'b0;
      for (int k = 0; k < 40; k++) begin
         @(posedge clk);
         #1;
         if (done || busy) seen_done = 1'b1;
      end
      chk("abort_no_done", {63'd0, seen_done}, 64'd0);

      // MULT 3 * 4 after the abort, nominal timing
      launch("mul_3_4", 1'b0, 32'd3, 32'd4);
      run_to("mul_3_4", 35, 4'b1110);
      chk_result("mul_3_4", 32'd0, 32'd12);
      chk_idle("mul_3_4", 32'd0, 32'd12);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
